// File: rtl/bitwise_pkg.sv
// Shared definitions for the 4-bit bitwise/shift sequencing controller:
// op encodings, FSM state type and default widths.
package bitwise_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int SH_W_DEF  = 3;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_NOT_A = 3'b011;
  localparam logic [2:0] OP_NOT_B = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_alu_unit.sv
// Combinational single-step logic ops for the sequencing controller.
// Shift and illegal encodings yield zero; the controller handles those itself.
module bitwise_alu_unit
  import bitwise_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOT_A: y = ~a;
      OP_NOT_B: y = ~b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_seq_ctrl.sv
// Sequencing controller: accepts one op over valid/ready, runs logic ops in one
// step and multi-bit shifts one bit per cycle, then holds the result until taken.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// SHIFT | shifting acc by one bit per edge, cnt edges remaining
// DONE  | out_valid high, result/err held until out_ready
module bitwise_seq_ctrl
  import bitwise_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SH_W  = SH_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SH_W-1:0]  shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [SH_W-1:0]  cnt, cnt_nxt;
  logic             err_q, err_nxt;
  logic             shl_q, shl_nxt;
  logic [WIDTH-1:0] alu_y;
  logic [SH_W-1:0]  n_clamp;

  bitwise_alu_unit #(.WIDTH(WIDTH)) u_alu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (alu_y)
  );

  // Amounts beyond WIDTH would only shift in more zeros, so cap the iteration count.
  assign n_clamp = (shamt > SH_W'(WIDTH)) ? SH_W'(WIDTH) : shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
      shl_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      shl_q <= shl_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    shl_nxt   = shl_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          err_nxt   = 1'b0;
          state_nxt = DONE;
          if (op == OP_SHL || op == OP_SHR) begin
            shl_nxt = (op == OP_SHL);
            acc_nxt = (op == OP_SHL) ? a : b;
            cnt_nxt = n_clamp;
            if (n_clamp != '0) state_nxt = SHIFT;
          end else if (op == OP_ILL) begin
            acc_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            acc_nxt = alu_y;
          end
        end
      end
      SHIFT: begin
        acc_nxt = shl_q ? (acc << 1) : (acc >> 1);
        cnt_nxt = cnt - 1'b1;
        if (cnt == SH_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign result    = acc;
  assign err       = err_q;

endmodule

// File: tb/tb_bitwise_seq_ctrl.sv
// Self-checking bench for bitwise_seq_ctrl: vector table with a scoreboard queue,
// plus directed sequences for back-pressure, accept-cycle and async reset.
module tb_bitwise_seq_ctrl;
  import bitwise_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [2:0] op;
  logic [3:0] a, b;
  logic [2:0] shamt;
  logic       out_valid, out_ready;
  logic [3:0] result;
  logic       err, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] shamt;
    logic [3:0] res;
    logic       err;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       err;
    int         lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  bitwise_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request from IDLE, verify latency/busy, compare against the scoreboard
  // entry, then accept the result and check the return to IDLE.
  task automatic run_req(input vec_t v);
    int   k;
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    op = v.op; a = v.a; b = v.b; shamt = v.shamt; in_valid = 1'b1;
    sb.push_back('{v.res, v.err, v.lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~v.a; b = ~v.b; op = OP_AND; shamt = 3'd3;
    k = 1;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      chk("busy_shift", busy, 1);
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    chk("latency", k, e.lat);
    chk("out_valid", out_valid, 1);
    chk("result", result, e.res);
    chk("err", err, e.err);
    chk("in_ready_done", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_accept", out_valid, 0);
    chk("in_ready_after_accept", in_ready, 1);
  endtask

  initial begin
    logic [3:0] held_res;
    logic       held_err;
    in_valid = 0; out_ready = 0; op = OP_AND; a = 0; b = 0; shamt = 0;
    rst_n = 0;

    vecs.push_back('{OP_AND,   4'b1010, 4'b1100, 3'd0, 4'b1000, 1'b0, 1});
    vecs.push_back('{OP_OR,    4'b0101, 4'b0011, 3'd0, 4'b0111, 1'b0, 1});
    vecs.push_back('{OP_XOR,   4'b0101, 4'b0011, 3'd0, 4'b0110, 1'b0, 1});
    vecs.push_back('{OP_NOT_A, 4'b1010, 4'b1100, 3'd0, 4'b0101, 1'b0, 1});
    vecs.push_back('{OP_NOT_B, 4'b1010, 4'b1100, 3'd0, 4'b0011, 1'b0, 1});
    vecs.push_back('{OP_SHL,   4'b1001, 4'b0000, 3'd2, 4'b0100, 1'b0, 3});
    vecs.push_back('{OP_SHR,   4'b0000, 4'b0110, 3'd1, 4'b0011, 1'b0, 2});
    vecs.push_back('{OP_SHR,   4'b0000, 4'b1111, 3'd7, 4'b0000, 1'b0, 5});
    vecs.push_back('{OP_SHL,   4'b1010, 4'b0101, 3'd0, 4'b1010, 1'b0, 1});
    vecs.push_back('{OP_SHL,   4'b0001, 4'b1111, 3'd4, 4'b0000, 1'b0, 5});
    vecs.push_back('{OP_SHL,   4'b0011, 4'b1111, 3'd5, 4'b0000, 1'b0, 5});
    vecs.push_back('{OP_SHR,   4'b0110, 4'b1000, 3'd3, 4'b0001, 1'b0, 4});
    vecs.push_back('{OP_SHL,   4'b0111, 4'b0000, 3'd3, 4'b1000, 1'b0, 4});
    vecs.push_back('{OP_ILL,   4'b1111, 4'b1111, 3'd2, 4'b0000, 1'b1, 1});

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1;

    foreach (vecs[i]) run_req(vecs[i]);

    // Illegal op under back-pressure; in_valid pulses in DONE must be ignored.
    @(negedge clk);
    op = OP_ILL; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    held_res = result; held_err = err;
    chk("ill_valid", out_valid, 1);
    chk("ill_err", held_err, 1);
    chk("ill_result", held_res, 0);
    for (int i = 0; i < 5; i++) begin
      op = OP_NOT_A; a = 4'b0000; in_valid = (i % 2 == 0);
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 0);
      chk("bp_err", err, 1);
    end
    // Accept with in_valid high in the same cycle: request must not be taken.
    in_valid = 1; op = OP_NOT_A; a = 4'b0000; out_ready = 1;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    chk("no_accept_in_done", out_valid, 0);
    chk("idle_after_accept", in_ready, 1);
    @(negedge clk);
    chk("still_idle", out_valid, 0);

    // Asynchronous reset in the middle of a shift.
    op = OP_SHL; a = 4'b1111; shamt = 3'd4; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #2;
    chk("pre_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    run_req('{OP_AND, 4'b1010, 4'b1100, 3'd0, 4'b1000, 1'b0, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
